// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand bypass, single-bubble load-use stall and flush.
// Define OPSTAGE_PERF_EN to build the stall/forward performance counters; otherwise they read 0.
module id_ex_operand_stage #(
    parameter int XLEN = 32,
    parameter int RAW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_pc,
    input  logic [RAW-1:0]  id_rs1,
    input  logic [RAW-1:0]  id_rs2,
    input  logic [XLEN-1:0] id_rs1_val,
    input  logic [XLEN-1:0] id_rs2_val,
    input  logic [XLEN-1:0] id_imm,
    input  logic            id_use_imm,
    input  logic            id_use_pc,
    input  logic [4:0]      id_aluop,
    input  logic [RAW-1:0]  id_rd,
    input  logic            id_rd_we,
    input  logic            id_is_load,
    input  logic            ex_ready,
    input  logic            flush,
    input  logic [RAW-1:0]  mem_rd,
    input  logic            mem_rd_we,
    input  logic            mem_is_load,
    input  logic [XLEN-1:0] mem_val,
    input  logic [RAW-1:0]  wb_rd,
    input  logic            wb_rd_we,
    input  logic [XLEN-1:0] wb_val,
    output logic            ex_valid,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [4:0]      alu_c,
    output logic [XLEN-1:0] ex_store_data,
    output logic [XLEN-1:0] ex_pc,
    output logic [RAW-1:0]  ex_rd,
    output logic            ex_rd_we,
    output logic            ex_is_load,
    output logic [31:0]     perf_stall,
    output logic [31:0]     perf_fwd
);

    logic            exValid;
    logic [XLEN-1:0] exPc;
    logic [RAW-1:0]  exRs1;
    logic [RAW-1:0]  exRs2;
    logic [XLEN-1:0] exRs1Val;
    logic [XLEN-1:0] exRs2Val;
    logic [XLEN-1:0] exImm;
    logic            exUseImm;
    logic            exUsePc;
    logic [4:0]      exAluop;
    logic [RAW-1:0]  exRd;
    logic            exRdWe;
    logic            exIsLoad;

    logic            hazard;
    logic            idReady;
    logic            transfer;

    logic            memHitRs1;
    logic            memHitRs2;
    logic            wbHitRs1;
    logic            wbHitRs2;
    logic [XLEN-1:0] fwdRs1;
    logic [XLEN-1:0] fwdRs2;

    assign hazard = exValid & exIsLoad & (exRd != '0) & id_valid &
                    ((id_rs1 == exRd) | (id_rs2 == exRd));
    assign idReady  = (~exValid | ex_ready) & ~hazard & ~flush;
    assign transfer = id_valid & idReady;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exValid  <= 1'b0;
            exPc     <= '0;
            exRs1    <= '0;
            exRs2    <= '0;
            exRs1Val <= '0;
            exRs2Val <= '0;
            exImm    <= '0;
            exUseImm <= 1'b0;
            exUsePc  <= 1'b0;
            exAluop  <= '0;
            exRd     <= '0;
            exRdWe   <= 1'b0;
            exIsLoad <= 1'b0;
        end else if (flush) begin
            exValid <= 1'b0;
        end else if (transfer) begin
            exValid  <= 1'b1;
            exPc     <= id_pc;
            exRs1    <= id_rs1;
            exRs2    <= id_rs2;
            exRs1Val <= id_rs1_val;
            exRs2Val <= id_rs2_val;
            exImm    <= id_imm;
            exUseImm <= id_use_imm;
            exUsePc  <= id_use_pc;
            exAluop  <= id_aluop;
            exRd     <= id_rd;
            exRdWe   <= id_rd_we;
            exIsLoad <= id_is_load;
        end else if (ex_ready) begin
            // Covers both the load-use bubble and a plain drain; fields hold either way.
            exValid <= 1'b0;
        end
    end

    // Loads in MEM have no data yet, so only ALU results bypass from MEM.
    assign memHitRs1 = mem_rd_we & ~mem_is_load & (mem_rd == exRs1);
    assign memHitRs2 = mem_rd_we & ~mem_is_load & (mem_rd == exRs2);
    assign wbHitRs1  = wb_rd_we & (wb_rd == exRs1);
    assign wbHitRs2  = wb_rd_we & (wb_rd == exRs2);

    always_comb begin
        fwdRs1 = exRs1Val;
        if (exRs1 == '0)
            fwdRs1 = '0;
        else if (memHitRs1)
            fwdRs1 = mem_val;
        else if (wbHitRs1)
            fwdRs1 = wb_val;
    end

    always_comb begin
        fwdRs2 = exRs2Val;
        if (exRs2 == '0)
            fwdRs2 = '0;
        else if (memHitRs2)
            fwdRs2 = mem_val;
        else if (wbHitRs2)
            fwdRs2 = wb_val;
    end

    assign id_ready      = idReady;
    assign ex_valid      = exValid;
    assign alu_a         = exUsePc ? exPc : fwdRs1;
    assign alu_b         = exUseImm ? exImm : fwdRs2;
    assign alu_c         = exAluop;
    assign ex_store_data = fwdRs2;
    assign ex_pc         = exPc;
    assign ex_rd         = exRd;
    assign ex_rd_we      = exRdWe;
    assign ex_is_load    = exIsLoad;

`ifdef OPSTAGE_PERF_EN
    logic [31:0] stallCnt;
    logic [31:0] fwdCnt;
    logic        bubble;
    logic        rs1Fwd;
    logic        rs2Fwd;
    logic [1:0]  fwdInc;
    logic [32:0] fwdSum;

    assign bubble = hazard & ex_ready & ~flush;
    assign rs1Fwd = (exRs1 != '0) & (memHitRs1 | wbHitRs1);
    assign rs2Fwd = (exRs2 != '0) & (memHitRs2 | wbHitRs2);
    assign fwdInc = (exValid & ex_ready) ? ({1'b0, rs1Fwd} + {1'b0, rs2Fwd}) : 2'd0;
    assign fwdSum = {1'b0, fwdCnt} + {31'd0, fwdInc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt <= '0;
            fwdCnt   <= '0;
        end else begin
            if (bubble && (stallCnt != 32'hFFFF_FFFF))
                stallCnt <= stallCnt + 32'd1;
            fwdCnt <= fwdSum[32] ? 32'hFFFF_FFFF : fwdSum[31:0];
        end
    end

    assign perf_stall = stallCnt;
    assign perf_fwd   = fwdCnt;
`else
    assign perf_stall = 32'd0;
    assign perf_fwd   = 32'd0;
`endif

endmodule
